// File: rtl/fifo_word_serializer.sv
// Pops one WORDS-wide packet from a FIFO head and streams it out one word per valid/ready beat.
// The first word appears the cycle after o_pull. i_ready low holds the current word. One idle cycle separates packets.
module fifo_word_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = 4,
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_available,
  input  logic [WORD_WIDTH-1:0] i_words [WORDS-1:0],
  output logic                  o_pull,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic [IDX_W-1:0]      o_index,
  output logic                  o_last,
  input  logic                  i_flush,
  output logic [15:0]           o_pkt_cnt
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SEND  = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_index;
  logic [WORD_WIDTH-1:0] r_buf [WORDS-1:0];
  logic [15:0]           r_pkt_cnt;

  logic w_idle;
  logic w_send;
  logic w_pull;
  logic w_at_last;
  logic w_xfer;

  assign w_idle    = (r_state == ST_IDLE);
  // Reset masks the held packet immediately, before the clock edge clears it.
  assign w_send    = (r_state == ST_SEND) & ~i_rst;
  assign w_pull    = w_idle & i_available & ~i_flush & ~i_rst;
  assign w_at_last = (r_index == LAST_IDX);
  assign w_xfer    = w_send & i_ready & ~i_flush;

  assign o_pull    = w_pull;
  assign o_valid   = w_send;
  assign o_data    = i_rst ? '0 : r_buf[r_index];
  assign o_index   = i_rst ? '0 : r_index;
  assign o_last    = w_send & w_at_last;
  assign o_pkt_cnt = r_pkt_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_pkt_cnt <= '0;
      for (int k = 0; k < WORDS; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_pull) begin
      r_buf   <= i_words;
      r_index <= '0;
      r_state <= ST_SEND;
    end else if (w_send && i_flush) begin
      r_state <= ST_IDLE;
      r_index <= '0;
    end else if (w_xfer) begin
      if (w_at_last) begin
        r_state   <= ST_IDLE;
        r_index   <= '0;
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end else begin
        r_index <= r_index + IDX_W'(1);
      end
    end
  end

  a_no_pull_while_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_pull && o_valid));

  a_hold_on_stall: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready && !i_flush) |=> ($stable(o_data) && $stable(o_index)));

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Randomized bench for fifo_word_serializer: a queue-of-words reference model predicts every output each cycle.
module tb_fifo_word_serializer;

  localparam int WW = 32;
  localparam int NW = 4;
  localparam int IW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_available = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_flush = 1'b0;
  logic [WW-1:0] i_words [NW-1:0];
  logic          o_pull;
  logic          o_valid;
  logic [WW-1:0] o_data;
  logic [IW-1:0] o_index;
  logic          o_last;
  logic [15:0]   o_pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words still owed downstream from the held packet, plus delivered packet count.
  logic [WW-1:0] m_q [$];
  logic [15:0]   m_cnt = 16'd0;
  logic          e_pull;
  logic          e_valid;
  logic          e_last;
  logic [WW-1:0] e_data;
  logic [IW-1:0] e_index;

  always #5 i_clk = ~i_clk;

  fifo_word_serializer #(.WORD_WIDTH(WW), .WORDS(NW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_available (i_available),
    .i_words     (i_words),
    .o_pull      (o_pull),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_index     (o_index),
    .o_last      (o_last),
    .i_flush     (i_flush),
    .o_pkt_cnt   (o_pkt_cnt)
  );

  task automatic m_eval();
    e_valid = (m_q.size() != 0) && !i_rst;
    e_pull  = (m_q.size() == 0) && i_available && !i_flush && !i_rst;
    e_last  = e_valid && (m_q.size() == 1);
    e_index = e_valid ? IW'(NW - m_q.size()) : '0;
    e_data  = e_valid ? m_q[0] : '0;
  endtask

  task automatic m_step();
    if (i_rst) begin
      m_q.delete();
      m_cnt = 16'd0;
    end else if (e_pull) begin
      for (int k = 0; k < NW; k++) m_q.push_back(i_words[k]);
    end else if (m_q.size() != 0) begin
      if (i_flush) begin
        m_q.delete();
      end else if (i_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  // Retires the previous clock edge into the model, applies new inputs, then predicts outputs.
  task automatic drive(input logic av, input logic rd, input logic fl, input logic rs);
    @(negedge i_clk);
    m_step();
    i_available = av;
    i_ready     = rd;
    i_flush     = fl;
    i_rst       = rs;
    for (int k = 0; k < NW; k++) i_words[k] = $urandom;
    #1;
    m_eval();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1);
      n_checks += 6;
      if (o_pull !== 1'b0) begin n_fail++; $display("FAIL reset.pull c=%0d got=%b exp=0", c, o_pull); end
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset.valid c=%0d got=%b exp=0", c, o_valid); end
      if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset.last c=%0d got=%b exp=0", c, o_last); end
      if (o_data !== '0) begin n_fail++; $display("FAIL reset.data c=%0d got=%h exp=0", c, o_data); end
      if (o_index !== '0) begin n_fail++; $display("FAIL reset.index c=%0d got=%0d exp=0", c, o_index); end
      if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset.cnt c=%0d got=%0d exp=0", c, o_pkt_cnt); end
    end
  endtask

  task automatic test_single();
    int pulls = 0;
    int beats = 0;
    logic [15:0] cnt0;
    cnt0 = m_cnt;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 1'b1, 1'b0, 1'b0);
      n_checks += 5;
      if (o_pull !== e_pull) begin n_fail++; $display("FAIL single.pull c=%0d got=%b exp=%b", c, o_pull, e_pull); end
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL single.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL single.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL single.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL single.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL single.data c=%0d got=%h exp=%h", c, o_data, e_data); end
      end
      pulls += int'(o_pull);
      beats += int'(o_valid && i_ready);
    end
    n_checks += 3;
    if (pulls != 1) begin n_fail++; $display("FAIL single.npull got=%0d exp=1", pulls); end
    if (beats != NW) begin n_fail++; $display("FAIL single.nbeat got=%0d exp=%0d", beats, NW); end
    if (o_pkt_cnt !== cnt0 + 16'd1) begin n_fail++; $display("FAIL single.cntend got=%0d exp=%0d", o_pkt_cnt, cnt0 + 16'd1); end
  endtask

  task automatic test_stall();
    logic [WW-1:0] pkt [NW];
    logic          rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int            beats = 0;
    drive(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    for (int k = 0; k < NW; k++) pkt[k] = i_words[k];
    n_checks++;
    if (o_pull !== 1'b1) begin n_fail++; $display("FAIL stall.pull got=%b exp=1", o_pull); end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c < 7) ? rdy_pat[c] : 1'b1, 1'b0, 1'b0);
      n_checks += 4;
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL stall.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL stall.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL stall.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL stall.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (o_valid && i_ready && beats < NW) begin
        n_checks++;
        if (o_data !== pkt[beats]) begin n_fail++; $display("FAIL stall.data beat=%0d got=%h exp=%h", beats, o_data, pkt[beats]); end
      end
      beats += int'(o_valid && i_ready);
    end
    n_checks++;
    if (beats != NW) begin n_fail++; $display("FAIL stall.nbeat got=%0d exp=%0d", beats, NW); end
  endtask

  task automatic test_back_to_back();
    int pull_at [$];
    int beats = 0;
    for (int c = 0; c < 17; c++) begin
      drive(c < 15, 1'b1, 1'b0, 1'b0);
      n_checks += 4;
      if (o_pull !== e_pull) begin n_fail++; $display("FAIL b2b.pull c=%0d got=%b exp=%b", c, o_pull, e_pull); end
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL b2b.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL b2b.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL b2b.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL b2b.data c=%0d got=%h exp=%h", c, o_data, e_data); end
      end
      if (o_pull) pull_at.push_back(c);
      beats += int'(o_valid && i_ready);
    end
    n_checks += 2;
    if (pull_at.size() != 3) begin n_fail++; $display("FAIL b2b.npull got=%0d exp=3", pull_at.size()); end
    if (beats != 3 * NW) begin n_fail++; $display("FAIL b2b.nbeat got=%0d exp=%0d", beats, 3 * NW); end
    for (int i = 1; i < pull_at.size(); i++) begin
      n_checks++;
      if (pull_at[i] - pull_at[i-1] != NW + 1) begin
        n_fail++; $display("FAIL b2b.spacing i=%0d got=%0d exp=%0d", i, pull_at[i] - pull_at[i-1], NW + 1);
      end
    end
  endtask

  task automatic test_flush();
    // columns: available, ready, flush
    logic [2:0] tbl [11] = '{3'b110, 3'b010, 3'b010, 3'b011, 3'b110, 3'b010,
                             3'b010, 3'b010, 3'b010, 3'b111, 3'b000};
    logic [15:0] cnt0;
    cnt0 = m_cnt;
    for (int c = 0; c < 11; c++) begin
      drive(tbl[c][2], tbl[c][1], tbl[c][0], 1'b0);
      n_checks += 5;
      if (o_pull !== e_pull) begin n_fail++; $display("FAIL flush.pull c=%0d got=%b exp=%b", c, o_pull, e_pull); end
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL flush.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL flush.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL flush.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL flush.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL flush.data c=%0d got=%h exp=%h", c, o_data, e_data); end
      end
      if (c == 4) begin
        n_checks += 2;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush.dropvalid got=%b exp=0", o_valid); end
        if (o_pkt_cnt !== cnt0) begin n_fail++; $display("FAIL flush.dropcnt got=%0d exp=%0d", o_pkt_cnt, cnt0); end
      end
      if (c == 5) begin
        n_checks++;
        if (o_index !== '0) begin n_fail++; $display("FAIL flush.restart got=%0d exp=0", o_index); end
      end
      if (c == 9) begin
        n_checks++;
        if (o_pull !== 1'b0) begin n_fail++; $display("FAIL flush.idlepull got=%b exp=0", o_pull); end
      end
    end
    n_checks++;
    if (o_pkt_cnt !== cnt0 + 16'd1) begin n_fail++; $display("FAIL flush.cntend got=%0d exp=%0d", o_pkt_cnt, cnt0 + 16'd1); end
  endtask

  task automatic test_reset_mid();
    // columns: available, ready, rst
    logic [2:0] tbl [11] = '{3'b110, 3'b010, 3'b010, 3'b011, 3'b011, 3'b110,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    for (int c = 0; c < 11; c++) begin
      drive(tbl[c][2], tbl[c][1], 1'b0, tbl[c][0]);
      n_checks += 5;
      if (o_pull !== e_pull) begin n_fail++; $display("FAIL rstmid.pull c=%0d got=%b exp=%b", c, o_pull, e_pull); end
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL rstmid.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL rstmid.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL rstmid.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL rstmid.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (e_valid || i_rst) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL rstmid.data c=%0d got=%h exp=%h", c, o_data, e_data); end
      end
      if (c == 5) begin
        n_checks += 2;
        if (o_pull !== 1'b1) begin n_fail++; $display("FAIL rstmid.firstpull got=%b exp=1", o_pull); end
        if (o_pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid.cntzero got=%0d exp=0", o_pkt_cnt); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      n_checks += 5;
      if (o_pull !== e_pull) begin n_fail++; $display("FAIL rand.pull c=%0d got=%b exp=%b", c, o_pull, e_pull); end
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL rand.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_index !== e_index) begin n_fail++; $display("FAIL rand.index c=%0d got=%0d exp=%0d", c, o_index, e_index); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL rand.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL rand.cnt c=%0d got=%0d exp=%0d", c, o_pkt_cnt, m_cnt); end
      if (e_valid || i_rst) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL rand.data c=%0d got=%h exp=%h", c, o_data, e_data); end
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    // Counting 65535 real packets is too slow; preload the counter while idle instead.
    force dut.r_pkt_cnt = 16'hFFFF;
    #1;
    release dut.r_pkt_cnt;
    m_cnt = 16'hFFFF;
    for (int c = 0; c < 7; c++) begin
      drive(c == 1, 1'b1, 1'b0, 1'b0);
      n_checks += 3;
      if (o_valid !== e_valid) begin n_fail++; $display("FAIL wrap.valid c=%0d got=%b exp=%b", c, o_valid, e_valid); end
      if (o_last !== e_last) begin n_fail++; $display("FAIL wrap.last c=%0d got=%b exp=%b", c, o_last, e_last); end
      if (o_pkt_cnt !== m_cnt) begin n_fail++; $display("FAIL wrap.cnt c=%0d got=%h exp=%h", c, o_pkt_cnt, m_cnt); end
    end
    n_checks++;
    if (o_pkt_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap.cntend got=%h exp=0000", o_pkt_cnt); end
  endtask

  initial begin
    for (int k = 0; k < NW; k++) i_words[k] = '0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
